// File: rtl/uart_rx_gen_pkg.sv
// Shared types and constants for the parametrised UART receiver.
// Also holds the prescale clamp helper.
package uart_rx_gen_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        STOP2,
        WAIT_IDLE
    } state_t;

    localparam int unsigned PRESCALE_MIN = 8;
    localparam logic        PAR_EVEN     = 1'b0;
    localparam logic        PAR_ODD      = 1'b1;

    // Clamp to the minimum oversampling ratio and force the ratio even so mid is exact.
    function automatic int unsigned eff_prescale(input int unsigned p);
        int unsigned q;
        q = (p < PRESCALE_MIN) ? PRESCALE_MIN : p;
        return q & ~32'd1;
    endfunction

endpackage

// File: rtl/uart_rx_gen_sampler.sv
// Three-point majority sampler around the bit centre.
// The vote is registered on the mid+1 edge and is readable from count mid+2.
module rx_majority_sampler #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [CNT_W-1:0] edge_cnt,
    input  logic [CNT_W-1:0] mid,
    input  logic             rxs,
    output logic             voted
);

    logic s_lo;
    logic s_mid;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s_lo  <= 1'b1;
            s_mid <= 1'b1;
            voted <= 1'b1;
        end else begin
            if (edge_cnt == mid - 1'b1) s_lo  <= rxs;
            if (edge_cnt == mid)        s_mid <= rxs;
            if (edge_cnt == mid + 1'b1)
                voted <= (s_lo & s_mid) | (s_lo & rxs) | (s_mid & rxs);
        end
    end

endmodule

// File: rtl/uart_rx_gen.sv
// Parametrised UART receiver: majority-voted sampling, optional parity and second stop bit,
// valid/ready holding register with overrun and break reporting.
module uart_rx_gen
    import uart_rx_gen_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [PRESCALE_W-1:0] prescale_in,
    input  logic                  rx_in,
    input  logic                  par_en_in,
    input  logic                  par_type_in,
    input  logic                  stop2_in,
    output logic [DATA_W-1:0]     data_out,
    output logic                  data_valid_out,
    input  logic                  data_ready_in,
    output logic                  par_err_out,
    output logic                  frm_err_out,
    output logic                  overrun_out,
    output logic                  break_out
);

    state_t                state, state_nxt;
    logic                  sync1, rxs;
    logic [PRESCALE_W-1:0] ps, ps_nxt, mid, edge_cnt, edge_nxt;
    logic [3:0]            bit_cnt, bit_nxt;
    logic [DATA_W-1:0]     shreg, shreg_nxt;
    logic                  par_bit, par_bit_nxt;
    logic                  pe, pe_nxt, fe, fe_nxt;
    logic                  voted, decide, wrap;
    logic                  complete, brk;

    assign mid    = ps >> 1;
    assign wrap   = (edge_cnt == ps - 1'b1);
    assign decide = (edge_cnt == mid + PRESCALE_W'(2));

    rx_majority_sampler #(.CNT_W(PRESCALE_W)) u_sampler (
        .clk      (clk),
        .reset_n  (reset_n),
        .edge_cnt (edge_cnt),
        .mid      (mid),
        .rxs      (rxs),
        .voted    (voted)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1    <= 1'b1;
            rxs      <= 1'b1;
            state    <= IDLE;
            edge_cnt <= '0;
            bit_cnt  <= '0;
            ps       <= PRESCALE_W'(PRESCALE_MIN);
            shreg    <= '0;
            par_bit  <= 1'b0;
            pe       <= 1'b0;
            fe       <= 1'b0;
        end else begin
            sync1    <= rx_in;
            rxs      <= sync1;
            state    <= state_nxt;
            edge_cnt <= edge_nxt;
            bit_cnt  <= bit_nxt;
            ps       <= ps_nxt;
            shreg    <= shreg_nxt;
            par_bit  <= par_bit_nxt;
            pe       <= pe_nxt;
            fe       <= fe_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        edge_nxt    = wrap ? '0 : edge_cnt + 1'b1;
        bit_nxt     = bit_cnt;
        ps_nxt      = ps;
        shreg_nxt   = shreg;
        par_bit_nxt = par_bit;
        pe_nxt      = pe;
        fe_nxt      = fe;
        complete    = 1'b0;
        brk         = 1'b0;
        case (state)
            IDLE: begin
                bit_nxt = '0;
                if (!rxs) begin
                    state_nxt   = START;
                    ps_nxt      = PRESCALE_W'(eff_prescale(32'(prescale_in)));
                    par_bit_nxt = 1'b0;
                    pe_nxt      = 1'b0;
                    fe_nxt      = 1'b0;
                end
            end
            START: begin
                if (decide && voted) state_nxt = IDLE;
                else if (wrap)       state_nxt = DATA;
            end
            DATA: begin
                if (decide) shreg_nxt = {voted, shreg[DATA_W-1:1]};
                if (wrap) begin
                    if (bit_cnt == 4'(DATA_W - 1)) begin
                        bit_nxt   = '0;
                        state_nxt = par_en_in ? PARITY : STOP;
                    end else begin
                        bit_nxt = bit_cnt + 4'd1;
                    end
                end
            end
            PARITY: begin
                if (decide) begin
                    par_bit_nxt = voted;
                    pe_nxt      = voted ^ (^shreg) ^ (par_type_in != PAR_EVEN);
                end
                if (wrap) state_nxt = STOP;
            end
            STOP: begin
                // Completion happens mid-bit so a start edge right after the stop bit is not missed.
                if (decide) begin
                    if (!voted && shreg == '0 && !(par_en_in && par_bit)) begin
                        brk       = 1'b1;
                        state_nxt = WAIT_IDLE;
                    end else if (!voted) begin
                        fe_nxt    = 1'b1;
                        complete  = 1'b1;
                        state_nxt = WAIT_IDLE;
                    end else if (!stop2_in) begin
                        complete  = 1'b1;
                        state_nxt = IDLE;
                    end
                end else if (wrap) begin
                    state_nxt = STOP2;
                end
            end
            STOP2: begin
                if (decide) begin
                    complete = 1'b1;
                    if (!voted) begin
                        fe_nxt    = 1'b1;
                        state_nxt = WAIT_IDLE;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                bit_nxt = '0;
                if (rxs) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (state_nxt == IDLE || state_nxt == WAIT_IDLE) edge_nxt = '0;
    end

    // Holding register: a completing frame is dropped only if the old one is not leaving this cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_out       <= '0;
            data_valid_out <= 1'b0;
            par_err_out    <= 1'b0;
            frm_err_out    <= 1'b0;
            overrun_out    <= 1'b0;
            break_out      <= 1'b0;
        end else begin
            overrun_out <= 1'b0;
            break_out   <= brk;
            if (complete && data_valid_out && !data_ready_in) begin
                overrun_out <= 1'b1;
            end else if (complete) begin
                data_out       <= shreg;
                par_err_out    <= pe;
                frm_err_out    <= fe_nxt;
                data_valid_out <= 1'b1;
            end else if (data_valid_out && data_ready_in) begin
                data_valid_out <= 1'b0;
            end
        end
    end

endmodule

// File: doc/uart_rx_gen.md
Name:
uart_rx_gen

Overview:
- Parametrised, next-generation UART receiver; replaces the fixed-width receiver in the UART front end of the multi-clock system.
- Adds configurable data width, oversampling range, one or two stop bits and 3-sample majority voting.
- Adds a valid/ready output holding register with overrun detection, plus per-frame parity, framing and break flags.
- Feeds the command decoder in the same clock domain.

Parameters:
- DATA_W, 8, data bits per frame; legal range 5..9.
- PRESCALE_W, 6, width of prescale_in; oversampling up to 2**PRESCALE_W-1.

Ports:
- clk  in  1  receiver clock.
- reset_n  in  1  reset; synchronous, active-low.
- prescale_in  in  PRESCALE_W  oversampling ratio, in clk cycles per bit; must be even and >= 8.
- rx_in  in  1  asynchronous serial line; idle high.
- par_en_in  in  1  1 = a parity bit follows the data bits.
- par_type_in  in  1  0 = even parity, 1 = odd parity.
- stop2_in  in  1  1 = two stop bits.
- data_out  out  DATA_W  received data, LSB first on the line.
- data_valid_out  out  1  holding register full.
- data_ready_in  in  1  consumer accepts data this cycle.
- par_err_out  out  1  parity error on the held frame; qualified by data_valid_out.
- frm_err_out  out  1  stop-bit error on the held frame; qualified by data_valid_out.
- overrun_out  out  1  1-cycle pulse: a completed frame was dropped.
- break_out  out  1  1-cycle pulse: break condition detected.

Behaviour:
- Reset (reset_n low at a clk edge):
  - All outputs 0.
  - FSM to IDLE; counters 0.
  - Both synchroniser flops set to 1.
  - Reset mid-frame discards the frame and any held data.
- Input path:
  - rx_in passes through a 2-flop synchroniser; rxs denotes its output.
  - All timing below is relative to rxs.
- Prescale handling:
  - prescale_in is latched on start detection into ps; mid-frame changes are ignored.
  - Values below 8 are clamped to 8. Odd values are rounded down.
  - mid = ps/2.
- Counters:
  - Edge counter runs 0..ps-1 per bit, then wraps.
  - Bit counter increments on each wrap.
- Sampling: rxs is sampled at edge counts mid-1, mid and mid+1; the bit value is the majority of the three.
- FSM states:
  - IDLE: waits for rxs = 0; then goes to START with edge count 0.
  - START: at count mid+1, a voted 1 is a glitch; return to IDLE with no outputs. Otherwise go to DATA at wrap.
  - DATA: DATA_W bits, LSB first, shifted in. After the last bit go to PARITY if par_en_in is 1, else to STOP.
  - PARITY: the voted bit is compared with the XOR of the data bits, XORed with par_type_in. A mismatch sets the parity error.
  - STOP: a voted 0 sets the frame error. If stop2_in is 1 and stop bit 1 was 1, go to STOP2 at wrap. Otherwise complete at count mid+1, not at wrap, so a back-to-back start edge is caught.
  - STOP2: a voted 0 sets the frame error; complete at count mid+1.
  - WAIT_IDLE: entered after a break or any frame error; returns to IDLE when rxs = 1.
- Completion: data, par_err and frm_err are loaded into the holding register on the next cycle; data_valid_out rises the same cycle.
- Holding register:
  - A transfer occurs on a clk edge where data_valid_out and data_ready_in are both 1. data_valid_out then falls unless a new frame loads in the same cycle.
  - Completion while valid, with no transfer that cycle: the frame is dropped, overrun_out pulses, and held data, flags and valid are unchanged.
  - Completion while valid, with a transfer that same cycle: the new frame loads, valid stays 1, and there is no overrun.
  - data_out and the error flags are stable while data_valid_out is 1.
- Break:
  - Condition: data all 0, parity bit 0 if parity is enabled, and first stop bit voted 0.
  - Response: break_out pulses in the completion cycle; nothing is loaded and there is no overrun. Go to WAIT_IDLE.
- Frame error, non-break: the frame is delivered with frm_err_out = 1, then the FSM goes to WAIT_IDLE.

Decomposition:
- Package uart_rx_gen_pkg:
  - state_t enum: IDLE, START, DATA, PARITY, STOP, STOP2, WAIT_IDLE.
  - PRESCALE_MIN = 8.
  - Parity-type constants PAR_EVEN = 0, PAR_ODD = 1.
- Sub-module rx_majority_sampler: edge count, mid and rxs in; registered voted bit out.

Test Plan:
- Byte with no parity: prescale 16, DATA_W 8, frame 0xA5, ready held 1 → exactly one valid cycle with data_out = 0xA5 and all flags 0.
- Parity error: par_en 1, even parity, frame 0x3C sent with parity bit 1 → data_out = 0x3C, par_err_out = 1, frm_err_out = 0.
- Glitch rejection: rx low for 3 cycles only at prescale 16 → no valid, FSM back in IDLE, the next clean frame 0x55 is received correctly.
- Overrun and simultaneous transfer:
  - Frames 0x11 then 0x22 back-to-back with ready low → data_out = 0x11, overrun_out pulses once.
  - Same two frames, with ready pulsed in the cycle 0x22 completes → data_out = 0x22, no overrun.
- Break: rx low for 12 bit-times, then high → break_out pulses once, data_valid_out stays 0, and a following frame 0x81 is received.
- Two stop bits with framing error: DATA_W 7, stop2 1, frame 0x5A with the second stop bit 0 → data_out = 0x5A, frm_err_out = 1. A reset asserted mid-frame clears all outputs to 0.
